// File: rtl/hh_pkg.sv
// Shared constants and helpers for the hh_neuron_bank spiking-neuron slice.
//   Default parameter values, index-width helper, saturating add.
package hh_pkg;

   localparam int unsigned N_NEURONS_DEF  = 4;
   localparam int unsigned V_WIDTH_DEF    = 8;
   localparam int unsigned I_WIDTH_DEF    = 8;
   localparam int unsigned LEAK_SHIFT_DEF = 3;
   localparam int unsigned THRESH_DEF     = 200;
   localparam int unsigned V_RESET_DEF    = 0;
   localparam int unsigned REFRAC_DEF     = 2;
   localparam int unsigned COUNT_W        = 8;

   // Width needed to index n items; never below 1 bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // a + b clamped at maxv (operands are small, no 32-bit wrap possible).
   function automatic int unsigned sat_add(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned maxv);
      int unsigned s;
      s = a + b;
      return (s > maxv) ? maxv : s;
   endfunction

endpackage

// File: rtl/hh_spike_fifo.sv
// Two-entry in-order event FIFO with valid/ready drain and sticky overflow.
//   push/push_data : enqueue request (dropped when full and not popping)
//   valid/data     : head entry (data is 0 when empty)
//   ready          : consumer accepts head
//   overflow       : set when an event is dropped, cleared only by reset
module hh_spike_fifo #(
   parameter int unsigned DATA_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   input  logic              ready,
   output logic              overflow
);

   logic              v1_q;
   logic [DATA_W-1:0] d1_q;
   logic              n_v0, n_v1, n_ovf;
   logic [DATA_W-1:0] n_d0, n_d1;

   // Pop first (shift tail into head), then place the push in the first free slot.
   always_comb begin
      n_v0  = valid;
      n_d0  = data;
      n_v1  = v1_q;
      n_d1  = d1_q;
      n_ovf = overflow;
      if (valid && ready) begin
         n_v0 = v1_q;
         n_d0 = v1_q ? d1_q : '0;
         n_v1 = 1'b0;
         n_d1 = '0;
      end
      if (push) begin
         if (!n_v0) begin
            n_v0 = 1'b1;
            n_d0 = push_data;
         end else if (!n_v1) begin
            n_v1 = 1'b1;
            n_d1 = push_data;
         end else begin
            n_ovf = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid    <= 1'b0;
         data     <= '0;
         v1_q     <= 1'b0;
         d1_q     <= '0;
         overflow <= 1'b0;
      end else begin
         valid    <= n_v0;
         data     <= n_d0;
         v1_q     <= n_v1;
         d1_q     <= n_d1;
         overflow <= n_ovf;
      end
   end

endmodule

// File: rtl/hh_neuron_bank.sv
// Time-multiplexed bank of leaky integrate-and-fire neurons sharing one datapath.
// A round-robin index updates one neuron per enabled cycle; spikes appear on
// spike_vec one cycle later and are queued as IDs in a 2-entry event FIFO.
//   clk, rst_n        : clock, async active-low reset
//   ena               : advance scheduler / perform update
//   stim_current      : packed per-neuron stimulus
//   mon_sel           : monitored neuron for state_out / count_out
//   state_out         : registered membrane value of mon_sel
//   spike_vec         : one-cycle spike pulses
//   ev_valid/ev_id/ev_ready/ev_overflow : spike ID event stream
//   count_out         : per-neuron spike count (SPIKE_COUNT_EN), else 0
// Optional feature macro: SPIKE_COUNT_EN
module hh_neuron_bank
   import hh_pkg::*;
#(
   parameter int unsigned N_NEURONS  = N_NEURONS_DEF,
   parameter int unsigned V_WIDTH    = V_WIDTH_DEF,
   parameter int unsigned I_WIDTH    = I_WIDTH_DEF,
   parameter int unsigned LEAK_SHIFT = LEAK_SHIFT_DEF,
   parameter int unsigned THRESH     = THRESH_DEF,
   parameter int unsigned V_RESET    = V_RESET_DEF,
   parameter int unsigned REFRAC     = REFRAC_DEF
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               ena,
   input  logic [N_NEURONS*I_WIDTH-1:0]       stim_current,
   input  logic [idx_width(N_NEURONS)-1:0]    mon_sel,
   output logic [V_WIDTH-1:0]                 state_out,
   output logic [N_NEURONS-1:0]               spike_vec,
   output logic                               ev_valid,
   output logic [idx_width(N_NEURONS)-1:0]    ev_id,
   input  logic                               ev_ready,
   output logic                               ev_overflow,
   output logic [COUNT_W-1:0]                 count_out
);

   localparam int unsigned IDX_W = idx_width(N_NEURONS);
   localparam int unsigned R_W   = idx_width(REFRAC + 1);
   localparam int unsigned V_MAX = (2 ** V_WIDTH) - 1;

   logic [V_WIDTH-1:0] v_q      [N_NEURONS];
   logic [R_W-1:0]     refrac_q [N_NEURONS];
   logic [IDX_W-1:0]   idx_q;

   logic [V_WIDTH-1:0] cur_v, leaked, next_v;
   logic [I_WIDTH-1:0] cur_i;
   logic [R_W-1:0]     cur_r, next_r;
   int unsigned        sum;
   logic               spike_c, push_c, mon_ok_c;

   // Shared update datapath for the neuron currently addressed by idx_q.
   always_comb begin
      cur_v   = v_q[idx_q];
      cur_r   = refrac_q[idx_q];
      cur_i   = stim_current[idx_q*I_WIDTH +: I_WIDTH];
      leaked  = cur_v - (cur_v >> LEAK_SHIFT);
      sum     = sat_add(32'(leaked), 32'(cur_i), V_MAX);
      spike_c = 1'b0;
      next_v  = V_WIDTH'(sum);
      next_r  = cur_r;
      if (cur_r != '0) begin
         next_r = cur_r - R_W'(1);
         next_v = V_WIDTH'(V_RESET);
      end else if (sum >= THRESH) begin
         spike_c = 1'b1;
         next_v  = V_WIDTH'(V_RESET);
         next_r  = R_W'(REFRAC);
      end
   end

   assign push_c = ena && spike_c;

   // Out-of-range monitor selects only exist when N is not a power of two.
   if (N_NEURONS < (2 ** IDX_W)) begin : g_mon_range
      assign mon_ok_c = (mon_sel < IDX_W'(N_NEURONS));
   end else begin : g_mon_full
      assign mon_ok_c = 1'b1;
   end

   // Neuron state, scheduler and registered monitor/spike outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q     <= '0;
         spike_vec <= '0;
         state_out <= '0;
         for (int i = 0; i < N_NEURONS; i++) begin
            v_q[i]      <= '0;
            refrac_q[i] <= '0;
         end
      end else begin
         spike_vec <= '0;
         state_out <= mon_ok_c ? v_q[mon_sel] : '0;
         if (ena) begin
            v_q[idx_q]       <= next_v;
            refrac_q[idx_q]  <= next_r;
            spike_vec[idx_q] <= spike_c;
            idx_q <= (idx_q == IDX_W'(N_NEURONS - 1)) ? '0 : idx_q + IDX_W'(1);
         end
      end
   end

`ifdef SPIKE_COUNT_EN
   logic [COUNT_W-1:0] cnt_q [N_NEURONS];

   // Saturating per-neuron spike counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_out <= '0;
         for (int i = 0; i < N_NEURONS; i++) cnt_q[i] <= '0;
      end else begin
         count_out <= mon_ok_c ? cnt_q[mon_sel] : '0;
         if (push_c && (cnt_q[idx_q] != '1)) cnt_q[idx_q] <= cnt_q[idx_q] + COUNT_W'(1);
      end
   end
`else
   assign count_out = '0;
`endif

   hh_spike_fifo #(
      .DATA_W (IDX_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_c),
      .push_data (idx_q),
      .valid     (ev_valid),
      .data      (ev_id),
      .ready     (ev_ready),
      .overflow  (ev_overflow)
   );

endmodule

// File: doc/hh_neuron_bank.md
Name: hh_neuron_bank

Overview:
Parametrised, time-multiplexed bank of N simplified integrate-and-fire neurons with leak and refractory period. All neurons share one update datapath. A round-robin scheduler updates one neuron per enabled clock.
Spikes are reported two ways: as a per-neuron pulse vector, and as an ID event stream through a 2-entry FIFO with valid/ready handshake. The bank is the multi-channel successor of the single-neuron core behind the 8-bit pin-level top.

Parameters:
N_NEURONS, 4, number of neurons (>=2)
V_WIDTH, 8, unsigned membrane state width
I_WIDTH, 8, unsigned stimulus width per neuron (<= V_WIDTH)
LEAK_SHIFT, 3, leak = V >> LEAK_SHIFT per update
THRESH, 200, fire when V_next >= THRESH
V_RESET, 0, membrane value after a spike and during refractory period
REFRAC, 2, number of refractory updates after a spike

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  scheduler advance/update enable
stim_current  in  N_NEURONS*I_WIDTH  packed stimulus; neuron i at [i*I_WIDTH +: I_WIDTH]
mon_sel  in  clog2(N_NEURONS)  neuron selected for state_out/count_out
state_out  out  V_WIDTH  registered membrane value of neuron mon_sel
spike_vec  out  N_NEURONS  one-cycle spike pulse per neuron
ev_valid  out  1  spike event available
ev_id  out  clog2(N_NEURONS)  neuron ID of head event
ev_ready  in  1  consumer accepts head event
ev_overflow  out  1  sticky flag: an event was dropped
count_out  out  8  spike count of neuron mon_sel (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): all V=0, refractory counters=0, idx=0, FIFO empty. state_out, spike_vec, ev_valid, ev_id, ev_overflow, count_out all 0.
- Scheduler: idx counts 0..N_NEURONS-1 and wraps to 0. It advances only on cycles with ena=1. When ena=0: no update, idx holds, spike_vec=0. The FIFO still drains when ena=0.
- Update of neuron idx (combinational from stored state, written at the clock edge):
  - If refrac[idx]>0: refrac--, V=V_RESET, no spike.
  - Else: sum = V - (V>>LEAK_SHIFT) + zero-extended I, computed at V_WIDTH+1 bits. Saturate to 2^V_WIDTH-1. The leak term can never underflow.
  - If sum >= THRESH: spike, V=V_RESET, refrac=REFRAC. Otherwise V=sum.
- Latency: update in cycle t makes spike_vec[idx] high during cycle t+1 only. The event is pushed at the same edge, so ev_valid can be high at t+1.
- FIFO: 2 entries, in-order.
  - Head is presented on ev_valid/ev_id. Pop when ev_valid && ev_ready.
  - ev_id holds stable while ev_valid && !ev_ready.
  - Push while full without a simultaneous pop: the event is dropped and ev_overflow is set. ev_overflow clears only on reset.
  - Push and pop in the same cycle while full: both happen, nothing is dropped.
  - Empty FIFO: ev_valid=0 and ev_id=0.
- Monitor: state_out <= V[mon_sel] every cycle, regardless of ena. If mon_sel >= N_NEURONS, state_out=0.
- Reset asserted mid-operation: all state is cleared immediately, including queued events. The first update after release is neuron 0.

Optional Feature:
SPIKE_COUNT_EN:
- Defined: each neuron has an 8-bit counter that increments on each of its spikes and saturates at 255. count_out is registered from counter[mon_sel], using the same out-of-range rule as state_out. Counters reset to 0.
- Undefined: no counters are built and count_out is tied to 0.

Decomposition:
- Package hh_pkg: the default width constants, the index-width helper (clog2 of N), and a saturating-add function.
- Sub-module hh_spike_fifo: 2-entry valid/ready FIFO with overflow flag, parametrised by data width.
- Neuron state is held in flat registers in hh_neuron_bank.

Test Plan:
1. Reset asserted, then released with ena=1 and all stim=0 -> all outputs stay 0; V stays 0 for 100 cycles.
2. Neuron 0 stim=64, others 0 -> neuron 0 V takes 64, 120, 169 on its first three updates. The 4th update gives sum 212, so spike_vec[0] pulses one cycle after it and V=0. The 5th and 6th updates hold V=0 (refractory); the 7th update gives V=64. ev_id=0 appears on the event stream.
3. All stim=255, ev_ready=0 -> first update round: ev_ids 0 and 1 are queued; events 2 and 3 are dropped and ev_overflow=1. Raise ev_ready -> IDs 0 then 1 come out in order, ev_valid drops, ev_overflow stays 1.
4. FIFO full and a new spike arrives on the same cycle ev_ready=1 -> the head pops, the new ID is enqueued, and ev_overflow does not change.
5. ena toggled 0 for 10 cycles mid-run -> V, idx and refractory counters are frozen and spike_vec=0. Updates resume at the same idx when ena returns to 1.
6. Reset pulsed while neuron 2 is refractory and the FIFO holds 1 entry -> all state clears asynchronously. After release, stim 64 on neuron 2 needs the full 4 updates to spike.
